spi_peripheral: RTL and testbench

//  SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) for the far end of the spi controller link.

---
 rtl/spi_peripheral_if.sv | 46 ++++
 rtl/spi_peripheral.sv | 188 ++++++++++++++++++
 tb/tb_spi_peripheral.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_peripheral_if.sv
// Bus bundle for spi_peripheral: SPI pins plus the TX/RX word streams.
// Defining SPI_PERIPH_FRAME_CNT_EN adds the frame_cnt_o word counter to the bundle.
interface spi_peripheral_if #(
  parameter int WIDTH = 8
);
  logic             SCLK_i;
  logic             CS_i;
  logic             MOSI_i;
  logic             MISO_o;
  logic             MISO_oe_o;
  logic [WIDTH-1:0] tx_data_i;
  logic             tx_valid_i;
  logic             tx_ready_o;
  logic [WIDTH-1:0] rx_data_o;
  logic             rx_valid_o;
  logic             underrun_o;
  logic             abort_o;
  logic             busy_o;
`ifdef SPI_PERIPH_FRAME_CNT_EN
  logic [15:0]      frame_cnt_o;

  modport master (
    output SCLK_i, CS_i, MOSI_i, tx_data_i, tx_valid_i,
    input  MISO_o, MISO_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           underrun_o, abort_o, busy_o, frame_cnt_o
  );

  modport slave (
    input  SCLK_i, CS_i, MOSI_i, tx_data_i, tx_valid_i,
    output MISO_o, MISO_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           underrun_o, abort_o, busy_o, frame_cnt_o
  );
`else
  modport master (
    output SCLK_i, CS_i, MOSI_i, tx_data_i, tx_valid_i,
    input  MISO_o, MISO_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           underrun_o, abort_o, busy_o
  );

  modport slave (
    input  SCLK_i, CS_i, MOSI_i, tx_data_i, tx_valid_i,
    output MISO_o, MISO_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           underrun_o, abort_o, busy_o
  );
`endif
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder (MSB first), SCLK/CS/MOSI oversampled in the clock_i domain.
// Define SPI_PERIPH_FRAME_CNT_EN to add frame_cnt_o (words completed since last CS rise).
module spi_peripheral #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b1}}
) (
  input logic             clock_i,
  input logic             reset_ni,
  spi_peripheral_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  logic [1:0]       sclkSync_q;
  logic [1:0]       csSync_q;
  logic [1:0]       mosiSync_q;
  logic             sclkPrev_q;
  logic             csPrev_q;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] bitCnt_q,   bitCnt_d;
  logic [WIDTH-1:0] txShift_q,  txShift_d;
  logic             fromHold_q, fromHold_d;
  logic [WIDTH-1:0] rxShift_q,  rxShift_d;
  logic [WIDTH-1:0] rxData_q,   rxData_d;
  logic             rxValid_q,  rxValid_d;
  logic             underrun_q, underrun_d;
  logic             abort_q,    abort_d;
  logic [WIDTH-1:0] holdData_q, holdData_d;
  logic             holdFull_q, holdFull_d;
`ifdef SPI_PERIPH_FRAME_CNT_EN
  logic [15:0]      frameCnt_q, frameCnt_d;
`endif

  logic             sclkRise;
  logic             sclkFall;
  logic             csRise;
  logic             csFall;
  logic             pushEn;
  logic [WIDTH-1:0] peekWord;

  assign sclkRise = sclkSync_q[1] & ~sclkPrev_q;
  assign sclkFall = ~sclkSync_q[1] & sclkPrev_q;
  assign csRise   = csSync_q[1] & ~csPrev_q;
  assign csFall   = ~csSync_q[1] & csPrev_q;

  // Push only into an empty holding reg, so a push can never collide with a pop.
  assign pushEn   = bus.tx_valid_i & ~holdFull_q;
  assign peekWord = holdFull_q ? holdData_q : FILL;

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    txShift_d  = txShift_q;
    fromHold_d = fromHold_q;
    rxShift_d  = rxShift_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    holdData_d = holdData_q;
    holdFull_d = holdFull_q;
`ifdef SPI_PERIPH_FRAME_CNT_EN
    frameCnt_d = frameCnt_q;
`endif

    if (pushEn) begin
      holdData_d = bus.tx_data_i;
      holdFull_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (csRise) begin
          state_d    = SHIFT;
          bitCnt_d   = '0;
          txShift_d  = peekWord;
          fromHold_d = holdFull_q;
`ifdef SPI_PERIPH_FRAME_CNT_EN
          frameCnt_d = '0;
`endif
        end
      end

      SHIFT: begin
        if (csFall) begin
          state_d  = IDLE;
          bitCnt_d = '0;
          abort_d  = (bitCnt_q != '0);
        end else if (sclkRise) begin
          rxShift_d = (rxShift_q << 1) | WIDTH'(mosiSync_q[1]);
          // The holding word is only consumed once its first bit has been clocked out.
          if (bitCnt_q == '0) begin
            if (fromHold_q) begin
              holdFull_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d  = '0;
            rxData_d  = rxShift_d;
            rxValid_d = 1'b1;
`ifdef SPI_PERIPH_FRAME_CNT_EN
            if (frameCnt_q != 16'hFFFF) begin
              frameCnt_d = frameCnt_q + 16'd1;
            end
`endif
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end else if (sclkFall) begin
          if (bitCnt_q == '0) begin
            txShift_d  = peekWord;
            fromHold_d = holdFull_q;
          end else begin
            txShift_d = txShift_q << 1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sclkSync_q <= '0;
      csSync_q   <= '0;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b0;
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      txShift_q  <= FILL;
      fromHold_q <= 1'b0;
      rxShift_q  <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      holdData_q <= '0;
      holdFull_q <= 1'b0;
`ifdef SPI_PERIPH_FRAME_CNT_EN
      frameCnt_q <= '0;
`endif
    end else begin
      sclkSync_q <= {sclkSync_q[0], bus.SCLK_i};
      csSync_q   <= {csSync_q[0], bus.CS_i};
      mosiSync_q <= {mosiSync_q[0], bus.MOSI_i};
      sclkPrev_q <= sclkSync_q[1];
      csPrev_q   <= csSync_q[1];
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      txShift_q  <= txShift_d;
      fromHold_q <= fromHold_d;
      rxShift_q  <= rxShift_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
      holdData_q <= holdData_d;
      holdFull_q <= holdFull_d;
`ifdef SPI_PERIPH_FRAME_CNT_EN
      frameCnt_q <= frameCnt_d;
`endif
    end
  end

  assign bus.MISO_o     = (state_q == SHIFT) & txShift_q[WIDTH-1];
  assign bus.MISO_oe_o  = (state_q == SHIFT);
  assign bus.busy_o     = (state_q == SHIFT);
  assign bus.tx_ready_o = ~holdFull_q;
  assign bus.rx_data_o  = rxData_q;
  assign bus.rx_valid_o = rxValid_q;
  assign bus.underrun_o = underrun_q;
  assign bus.abort_o    = abort_q;
`ifdef SPI_PERIPH_FRAME_CNT_EN
  assign bus.frame_cnt_o = frameCnt_q;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: table of single-word transfers plus
// hand-written sequences for back-to-back words, abort, trailing peek and reset.
module tb_spi_peripheral;

  localparam int HALF = 8;

  typedef struct {
    logic       doPush;
    logic [7:0] pushData;
    logic [7:0] mosiWord;
    logic [7:0] expMiso;
    logic [7:0] expRx;
    int         expUnderrun;
  } vec_t;

  logic clock = 1'b0;
  logic resetN;

  always #5 clock = ~clock;

  spi_peripheral_if #(.WIDTH(8)) bus();

  spi_peripheral #(.WIDTH(8), .FILL(8'hFF)) dut (
    .clock_i  (clock),
    .reset_ni (resetN),
    .bus      (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int rxPulses       = 0;
  int underrunPulses = 0;
  int abortPulses    = 0;

  // Pulses are registered, so sampling at the rising edge sees each one exactly once.
  always @(posedge clock) begin
    if (bus.rx_valid_o) rxPulses++;
    if (bus.underrun_o) underrunPulses++;
    if (bus.abort_o)    abortPulses++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pushWord(input logic [7:0] d);
    @(negedge clock);
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    @(negedge clock);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic csRise();
    @(negedge clock);
    bus.CS_i = 1'b1;
  endtask

  task automatic csFall();
    waitCycles(HALF);
    bus.CS_i = 1'b0;
    waitCycles(HALF);
  endtask

  // MISO is sampled just before each SCLK rise, as a mode-0 controller would.
  task automatic shiftBits(input int nBits, input logic [7:0] mosi, input int pushAt,
                           input logic [7:0] pushVal, output logic [7:0] miso, output logic oeSeen);
    miso   = 8'h00;
    oeSeen = 1'b1;
    for (int i = 0; i < nBits; i++) begin
      bus.MOSI_i = mosi[7-i];
      waitCycles(HALF);
      miso[7-i] = bus.MISO_o;
      oeSeen    = oeSeen & bus.MISO_oe_o;
      bus.SCLK_i = 1'b1;
      waitCycles(HALF);
      if (i == pushAt) pushWord(pushVal);
      bus.SCLK_i = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int         rx0, un0, ab0;
    logic [7:0] miso;
    logic       oe;
    string      tag;
    tag = $sformatf("vec%0d", idx);
    rx0 = rxPulses; un0 = underrunPulses; ab0 = abortPulses;
    if (v.doPush) pushWord(v.pushData);
    checkOutput({tag, " tx_ready before"}, 32'(bus.tx_ready_o), 32'(!v.doPush));
    csRise();
    shiftBits(8, v.mosiWord, -1, 8'h00, miso, oe);
    checkOutput({tag, " busy"}, 32'(bus.busy_o), 32'd1);
    csFall();
    checkOutput({tag, " miso word"}, 32'(miso), 32'(v.expMiso));
    checkOutput({tag, " miso_oe during"}, 32'(oe), 32'd1);
    checkOutput({tag, " rx_data"}, 32'(bus.rx_data_o), 32'(v.expRx));
    checkOutput({tag, " rx_valid count"}, 32'(rxPulses - rx0), 32'd1);
    checkOutput({tag, " underrun count"}, 32'(underrunPulses - un0), 32'(v.expUnderrun));
    checkOutput({tag, " abort count"}, 32'(abortPulses - ab0), 32'd0);
    checkOutput({tag, " tx_ready after"}, 32'(bus.tx_ready_o), 32'd1);
    checkOutput({tag, " miso_oe idle"}, 32'(bus.MISO_oe_o), 32'd0);
`ifdef SPI_PERIPH_FRAME_CNT_EN
    checkOutput({tag, " frame_cnt"}, 32'(bus.frame_cnt_o), 32'd1);
`endif
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] miso;
    logic [7:0] miso2;
    logic       oe;
    int         rx0, un0, ab0;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h81, 8'hFF, 8'h81, 1};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[3] = '{1'b1, 8'h96, 8'h01, 8'h96, 8'h01, 0};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1};

    resetN         = 1'b0;
    bus.SCLK_i     = 1'b0;
    bus.CS_i       = 1'b0;
    bus.MOSI_i     = 1'b0;
    bus.tx_data_i  = 8'h00;
    bus.tx_valid_i = 1'b0;
    waitCycles(4);

    checkOutput("reset MISO_o", 32'(bus.MISO_o), 32'd0);
    checkOutput("reset MISO_oe_o", 32'(bus.MISO_oe_o), 32'd0);
    checkOutput("reset tx_ready_o", 32'(bus.tx_ready_o), 32'd1);
    checkOutput("reset rx_data_o", 32'(bus.rx_data_o), 32'd0);
    checkOutput("reset pulses", 32'({bus.rx_valid_o, bus.underrun_o, bus.abort_o}), 32'd0);
    checkOutput("reset busy_o", 32'(bus.busy_o), 32'd0);
    resetN = 1'b1;
    waitCycles(4);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Two words under one CS; second word pushed after the first pop.
    $display("[TB] sequence: back-to-back words");
    rx0 = rxPulses; un0 = underrunPulses;
    pushWord(8'h11);
    csRise();
    shiftBits(8, 8'h12, 2, 8'h22, miso, oe);
    checkOutput("b2b rx word1", 32'(bus.rx_data_o), 32'h12);
    shiftBits(8, 8'h34, -1, 8'h00, miso2, oe);
    csFall();
    checkOutput("b2b miso word1", 32'(miso), 32'h11);
    checkOutput("b2b miso word2", 32'(miso2), 32'h22);
    checkOutput("b2b rx word2", 32'(bus.rx_data_o), 32'h34);
    checkOutput("b2b rx_valid count", 32'(rxPulses - rx0), 32'd2);
    checkOutput("b2b underrun count", 32'(underrunPulses - un0), 32'd0);
`ifdef SPI_PERIPH_FRAME_CNT_EN
    checkOutput("b2b frame_cnt", 32'(bus.frame_cnt_o), 32'd2);
`endif

    // CS dropped after 5 bits, then a full transfer.
    $display("[TB] sequence: abort");
    rx0 = rxPulses; ab0 = abortPulses;
    csRise();
    shiftBits(5, 8'hFF, -1, 8'h00, miso, oe);
    csFall();
    checkOutput("abort count", 32'(abortPulses - ab0), 32'd1);
    checkOutput("abort no rx_valid", 32'(rxPulses - rx0), 32'd0);
    checkOutput("abort rx_data held", 32'(bus.rx_data_o), 32'h34);
    rx0 = rxPulses;
    csRise();
    shiftBits(8, 8'hC3, -1, 8'h00, miso, oe);
    csFall();
    checkOutput("post-abort rx_data", 32'(bus.rx_data_o), 32'hC3);
    checkOutput("post-abort rx_valid count", 32'(rxPulses - rx0), 32'd1);
    checkOutput("post-abort miso", 32'(miso), 32'hFF);
    checkOutput("post-abort abort count", 32'(abortPulses - ab0), 32'd1);

    // Trailing SCLK fall peeks 8'h77 but must not pop it.
    $display("[TB] sequence: trailing peek");
    un0 = underrunPulses;
    pushWord(8'h5A);
    csRise();
    shiftBits(8, 8'h0F, 3, 8'h77, miso, oe);
    csFall();
    checkOutput("peek miso word1", 32'(miso), 32'h5A);
    checkOutput("peek holding kept", 32'(bus.tx_ready_o), 32'd0);
    csRise();
    shiftBits(8, 8'hF0, -1, 8'h00, miso, oe);
    csFall();
    checkOutput("peek miso word2", 32'(miso), 32'h77);
    checkOutput("peek tx_ready after", 32'(bus.tx_ready_o), 32'd1);
    checkOutput("peek underrun count", 32'(underrunPulses - un0), 32'd0);
    checkOutput("peek rx_data", 32'(bus.rx_data_o), 32'hF0);

    // Reset asserted mid-word with a word still in the holding reg.
    $display("[TB] sequence: reset mid-word");
    pushWord(8'h3C);
    csRise();
    shiftBits(3, 8'hAA, -1, 8'h00, miso, oe);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checkOutput("midreset MISO_oe_o", 32'(bus.MISO_oe_o), 32'd0);
    checkOutput("midreset MISO_o", 32'(bus.MISO_o), 32'd0);
    checkOutput("midreset tx_ready_o", 32'(bus.tx_ready_o), 32'd1);
    checkOutput("midreset rx_data_o", 32'(bus.rx_data_o), 32'd0);
    checkOutput("midreset busy_o", 32'(bus.busy_o), 32'd0);
`ifdef SPI_PERIPH_FRAME_CNT_EN
    checkOutput("midreset frame_cnt", 32'(bus.frame_cnt_o), 32'd0);
`endif
    bus.CS_i   = 1'b0;
    bus.SCLK_i = 1'b0;
    waitCycles(4);
    resetN = 1'b1;
    waitCycles(HALF);
    applyStimulus(vecs[1], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
